// File: rtl/keyboard_pkg.sv
// Shared scan-code constants and channel state type for the keyboard decoders.
// Bit 8 of a scan code is the E0 extended-prefix flag.
package keyboard_pkg;

    localparam int CODE_W_DEF = 9;

    localparam logic [CODE_W_DEF-1:0] KEY_LEFT  = 9'h16B;
    localparam logic [CODE_W_DEF-1:0] KEY_RIGHT = 9'h174;
    localparam logic [CODE_W_DEF-1:0] KEY_UP    = 9'h175;
    localparam logic [CODE_W_DEF-1:0] KEY_SPACE = 9'h029;
    localparam logic [CODE_W_DEF-1:0] KEY_ENTER = 9'h05A;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        REPEAT     = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// One tracked key: press/release FSM, typematic repeat counter and pulse outputs.
// Handshake: make_hit/brk_hit are single-cycle strobes already qualified by the code match.
module key_channel
    import keyboard_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       make_hit,
    input  logic       brk_hit,
    input  logic       repeat_en,
    output logic       is_pressed,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       toggle,
    output logic       repeat_pulse,
    output key_state_t state_dbg
);

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             expired;
    logic             press_go;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             rep_nxt;
    logic             toggle_nxt;

    assign expired   = (cnt == '0);
    // A release strobe in the same cycle always beats a press strobe.
    assign press_go  = make_hit && !brk_hit;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_pressed   <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle       <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            is_pressed   <= (state_nxt != IDLE);
            rise_pulse   <= rise_nxt;
            fall_pulse   <= fall_nxt;
            toggle       <= toggle_nxt;
            repeat_pulse <= rep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press_go) begin
                    state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (brk_hit) begin
                    state_nxt = IDLE;
                end else if (expired && repeat_en) begin
                    state_nxt = REPEAT;
                end
            end
            REPEAT: begin
                if (brk_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With repeat disabled an expired counter parks at zero, so enabling it
    // later fires on the very next cycle rather than waiting a full period.
    always_comb begin
        cnt_nxt    = cnt;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        rep_nxt    = 1'b0;
        toggle_nxt = toggle;
        case (state)
            IDLE: begin
                if (press_go) begin
                    rise_nxt   = 1'b1;
                    rep_nxt    = 1'b1;
                    toggle_nxt = ~toggle;
                    cnt_nxt    = DELAY_LOAD;
                end
            end
            PRESS_WAIT, REPEAT: begin
                if (brk_hit) begin
                    fall_nxt = 1'b1;
                    cnt_nxt  = '0;
                end else if (expired) begin
                    if (repeat_en) begin
                        rep_nxt = 1'b1;
                        cnt_nxt = PERIOD_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

endmodule

// File: rtl/multi_key_decoder.sv
// Tracks NUM_KEYS configurable scan codes with per-key press/repeat outputs and
// aggregate held-key status derived one cycle later from the registered channel state.
module multi_key_decoder
    import keyboard_pkg::*;
#(
    parameter int                           NUM_KEYS      = 4,
    parameter int                           CODE_W        = CODE_W_DEF,
    parameter logic [NUM_KEYS*CODE_W-1:0]   KEY_CODES     = {KEY_SPACE, KEY_UP, KEY_RIGHT, KEY_LEFT},
    parameter int                           REPEAT_DELAY  = 25_000_000,
    parameter int                           REPEAT_PERIOD = 5_000_000,
    parameter int                           CNT_W         = 25,
    localparam int                          POP_W         = $clog2(NUM_KEYS + 1),
    localparam int                          IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_W-1:0]     keyCode,
    input  logic                  make,
    input  logic                  brakee,
    input  logic [NUM_KEYS-1:0]   repeatEn,
    output logic [NUM_KEYS-1:0]   keyIsPressed,
    output logic [NUM_KEYS-1:0]   keyRisingEdgePulse,
    output logic [NUM_KEYS-1:0]   keyFallingEdgePulse,
    output logic [NUM_KEYS-1:0]   keyToggle,
    output logic [NUM_KEYS-1:0]   keyRepeatPulse,
    output logic                  anyPressed,
    output logic [POP_W-1:0]      pressedCount,
    output logic [IDX_W-1:0]      lastKeyIdx,
    output logic                  lastKeyValid,
    output logic [2*NUM_KEYS-1:0] dbg_state
);

    logic [NUM_KEYS-1:0] make_hit;
    logic [NUM_KEYS-1:0] brk_hit;
    logic [POP_W-1:0]    pop_cnt;
    logic [IDX_W-1:0]    press_idx;
    logic                press_seen;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_state_t ch_state;
        logic       code_eq;

        // Duplicate codes are allowed: every matching channel sees the strobe.
        assign code_eq     = (keyCode == KEY_CODES[i*CODE_W +: CODE_W]);
        assign make_hit[i] = code_eq && make;
        assign brk_hit[i]  = code_eq && brakee;

        key_channel #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .make_hit     (make_hit[i]),
            .brk_hit      (brk_hit[i]),
            .repeat_en    (repeatEn[i]),
            .is_pressed   (keyIsPressed[i]),
            .rise_pulse   (keyRisingEdgePulse[i]),
            .fall_pulse   (keyFallingEdgePulse[i]),
            .toggle       (keyToggle[i]),
            .repeat_pulse (keyRepeatPulse[i]),
            .state_dbg    (ch_state)
        );

        assign dbg_state[2*i +: 2] = ch_state;
    end

    // Rising pulses mark exactly the IDLE->PRESS_WAIT transitions; lowest index wins.
    always_comb begin
        pop_cnt    = '0;
        press_idx  = '0;
        press_seen = |keyRisingEdgePulse;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pop_cnt = pop_cnt + POP_W'(keyIsPressed[i]);
        end
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keyRisingEdgePulse[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anyPressed   <= 1'b0;
            pressedCount <= '0;
            lastKeyIdx   <= '0;
            lastKeyValid <= 1'b0;
        end else begin
            anyPressed   <= |keyIsPressed;
            pressedCount <= pop_cnt;
            if (press_seen) begin
                lastKeyIdx   <= press_idx;
                lastKeyValid <= 1'b1;
            end
        end
    end

endmodule
